// File: rtl/neuron_pkg.sv
// -----------------------------------------------------------------------------
// neuron_pkg
// Definitions shared by the perceptron-trainer sample sequencer:
//   - default parameter values (widths, epoch limit, memory latency)
//   - the sequencer FSM state encoding
//   - bit offsets of the {t, x2, x1} fields inside a sample memory word
// -----------------------------------------------------------------------------
package neuron_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 6;
    localparam int DEF_EPOCH_W   = 8;
    localparam int DEF_MAX_EPOCH = 100;
    localparam int DEF_MEM_LAT   = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_WAIT,
        ST_FETCH,
        ST_LAT,
        ST_PRESENT,
        ST_RESULT,
        ST_EPOCH_END,
        ST_DONE
    } seq_state_t;

    // Memory word layout is {t, x2, x1}, with x1 in the LSBs.
    localparam int X1_LSB = 0;

    function automatic int x2_lsb(input int data_w);
        return X1_LSB + data_w;
    endfunction

    function automatic int t_bit(input int data_w);
        return X1_LSB + 2 * data_w;
    endfunction

endpackage

// File: rtl/epoch_counter.sv
// -----------------------------------------------------------------------------
// epoch_counter
// Sample index and epoch counter for the train sequencer.
//   clk, rst     : clock, asynchronous active-high reset
//   n            : samples per epoch (N)
//   clear        : zero both index and epoch (session start)
//   idx_inc      : advance the index, wrapping from N-1 back to 0
//   epoch_inc    : index <- 0, epoch++ (held at MAX_EPOCH-1)
//   index, epoch : current sample index / zero-based epoch
//   last         : index is N-1
//   epoch_limit  : epoch is MAX_EPOCH-1, so no further epoch may start
// -----------------------------------------------------------------------------
module epoch_counter
    import neuron_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int EPOCH_W   = DEF_EPOCH_W,
    parameter int MAX_EPOCH = DEF_MAX_EPOCH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  n,
    input  logic               clear,
    input  logic               idx_inc,
    input  logic               epoch_inc,
    output logic [ADDR_W-1:0]  index,
    output logic [EPOCH_W-1:0] epoch,
    output logic               last,
    output logic               epoch_limit
);

    assign last        = (index == n - ADDR_W'(1));
    assign epoch_limit = (epoch >= EPOCH_W'(MAX_EPOCH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index <= '0;
            epoch <= '0;
        end else if (clear) begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values of last/epoch_limit, not ones updated mid-block.
            index <= '0;
            epoch <= '0;
        end else if (epoch_inc) begin
            index <= '0;
            if (!epoch_limit) begin
                epoch <= epoch + EPOCH_W'(1);
            end
        end else if (idx_inc) begin
            index <= last ? '0 : index + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/train_sequencer.sv
// -----------------------------------------------------------------------------
// train_sequencer
// Sample-delivery and epoch scheduler for the single-neuron perceptron trainer.
// Serves requestFlag/dataReady from a synchronous sample memory, flags the last
// sample of each epoch, counts misclassifications and decides whether another
// epoch runs.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : session start (IDLE only); sampleCount latched with it
//   requestFlag       : controller asks for the next sample (REQ_WAIT only)
//   ldRegFlag/yEqualt : per-sample result strobe / "output matched target"
//   memRd/memAddr     : read strobe and address to the sample memory
//   memData           : {t, x2, x1}, valid MEM_LAT cycles after memRd
//   x1, x2, t         : presented sample, held until the next capture
//   dataReady         : one-cycle "sample valid" pulse
//   flagEOF           : presented sample is index N-1
//   endFlag           : run another epoch (valid in EPOCH_END)
//   busy, converged   : session active / last session ended error-free
//   epochCount        : zero-based epoch; errCount: errors in current epoch
// -----------------------------------------------------------------------------
module train_sequencer
    import neuron_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int EPOCH_W   = DEF_EPOCH_W,
    parameter int MAX_EPOCH = DEF_MAX_EPOCH,
    parameter int MEM_LAT   = DEF_MEM_LAT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        sampleCount,
    input  logic                     requestFlag,
    input  logic                     ldRegFlag,
    input  logic                     yEqualt,
    output logic                     memRd,
    output logic [ADDR_W-1:0]        memAddr,
    input  logic [2*DATA_W:0]        memData,
    output logic signed [DATA_W-1:0] x1,
    output logic signed [DATA_W-1:0] x2,
    output logic                     t,
    output logic                     dataReady,
    output logic                     flagEOF,
    output logic                     endFlag,
    output logic                     busy,
    output logic                     converged,
    output logic [EPOCH_W-1:0]       epochCount,
    output logic [ADDR_W-1:0]        errCount
);

    localparam int X2_LSB = x2_lsb(DATA_W);
    localparam int T_BIT  = t_bit(DATA_W);
    localparam int LAT_W  = $clog2(MEM_LAT + 1);

    seq_state_t        state_q, state_d;
    logic [LAT_W-1:0]  lat_cnt;
    logic [ADDR_W-1:0] n_q;
    logic [ADDR_W-1:0] err_plus;
    logic              last, epoch_limit;
    logic              start_ok, ld_ok, lat_done, idx_inc, epoch_inc;

    assign start_ok  = (state_q == ST_IDLE) && start;
    assign ld_ok     = (state_q == ST_RESULT) && ldRegFlag;
    // lat_cnt holds the number of cycles elapsed since memRd.
    assign lat_done  = (state_q == ST_LAT) && (lat_cnt == LAT_W'(MEM_LAT));
    assign idx_inc   = ld_ok && !last;
    assign epoch_inc = (state_q == ST_EPOCH_END) && endFlag;

    // Saturating error count including the result currently being strobed.
    assign err_plus  = (!yEqualt && (errCount != '1)) ? errCount + ADDR_W'(1) : errCount;

    epoch_counter #(
        .ADDR_W    (ADDR_W),
        .EPOCH_W   (EPOCH_W),
        .MAX_EPOCH (MAX_EPOCH)
    ) u_epoch_counter (
        .clk         (clk),
        .rst         (rst),
        .n           (n_q),
        .clear       (start_ok),
        .idx_inc     (idx_inc),
        .epoch_inc   (epoch_inc),
        .index       (memAddr),
        .epoch       (epochCount),
        .last        (last),
        .epoch_limit (epoch_limit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can infer a latch.
        state_d   = state_q;
        memRd     = 1'b0;
        dataReady = 1'b0;
        flagEOF   = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = (sampleCount != '0) ? ST_REQ_WAIT : ST_DONE;
                end
            end
            ST_REQ_WAIT: begin
                if (requestFlag) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                memRd   = 1'b1;
                state_d = ST_LAT;
            end
            ST_LAT: begin
                if (lat_done) begin
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                dataReady = 1'b1;
                flagEOF   = last;
                state_d   = ST_RESULT;
            end
            ST_RESULT: begin
                flagEOF = last;
                if (ldRegFlag) begin
                    state_d = last ? ST_EPOCH_END : ST_REQ_WAIT;
                end
            end
            ST_EPOCH_END: begin
                state_d = endFlag ? ST_REQ_WAIT : ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the presented sample is reset too, so a mid-session rst
            // leaves no stale data on x1/x2/t.
            lat_cnt   <= '0;
            n_q       <= '0;
            x1        <= '0;
            x2        <= '0;
            t         <= 1'b0;
            errCount  <= '0;
            endFlag   <= 1'b0;
            converged <= 1'b0;
        end else begin
            if (start_ok) begin
                n_q       <= sampleCount;
                errCount  <= '0;
                converged <= 1'b0;
            end

            if (state_q == ST_FETCH) begin
                lat_cnt <= LAT_W'(1);
            end else if ((state_q == ST_LAT) && !lat_done) begin
                lat_cnt <= lat_cnt + LAT_W'(1);
            end

            if (lat_done) begin
                x1 <= memData[X1_LSB +: DATA_W];
                x2 <= memData[X2_LSB +: DATA_W];
                t  <= memData[T_BIT];
            end

            if (ld_ok) begin
                errCount <= err_plus;
                if (last) begin
                    endFlag <= (err_plus != '0) && !epoch_limit;
                end
            end

            if (state_q == ST_EPOCH_END) begin
                endFlag <= 1'b0;
                if (endFlag) begin
                    errCount <= '0;
                end else begin
                    converged <= (errCount == '0);
                end
            end
        end
    end

endmodule

// File: doc/train_sequencer.md
# train_sequencer

Sample-delivery and epoch scheduler for the single-neuron perceptron trainer. It answers the neuron controller's `requestFlag`/`dataReady` handshake by fetching `{x1,x2,t}` samples from a synchronous sample memory. It flags the last sample of each epoch (`flagEOF`) and counts misclassifications from `ldRegFlag`/`yEqualt`. At each epoch end it decides `endFlag`, which tells the controller whether to run another epoch.

## Interface
- `DATA_W`, 8, signed width of `x1`, `x2`.
- `ADDR_W`, 6, sample memory address width; max samples 2^ADDR_W−1.
- `EPOCH_W`, 8, epoch counter width.
- `MAX_EPOCH`, 100, epoch limit; valid range 1..2^EPOCH_W−1.
- `MEM_LAT`, 1, memory read latency in cycles; must be ≥1.

Ports:
- `clk  in  1` – single clock; all state on rising edge.
- `rst  in  1` – reset, asynchronous, active-high.
- `start  in  1` – session start; sampled only in IDLE.
- `sampleCount  in  ADDR_W` – N samples per epoch; latched on accepted `start`.
- `requestFlag  in  1` – controller requests the next sample; level input.
- `ldRegFlag  in  1` – controller result strobe, one cycle per sample.
- `yEqualt  in  1` – neuron output matches target; valid while `ldRegFlag`=1.
- `memRd  out  1` – memory read strobe.
- `memAddr  out  ADDR_W` – memory read address.
- `memData  in  2*DATA_W+1` – `{t, x2, x1}`, with x1 in the LSBs.
- `x1`, `x2  out  DATA_W` – presented sample; held until the next capture.
- `t  out  1` – presented target.
- `dataReady  out  1` – one-cycle pulse: sample valid.
- `flagEOF  out  1` – high while the presented sample is index N−1.
- `endFlag  out  1` – run another epoch.
- `busy  out  1` – session active.
- `converged  out  1` – last session ended with an error-free epoch.
- `epochCount  out  EPOCH_W` – current epoch, zero-based.
- `errCount  out  ADDR_W` – errors so far in the current epoch.

## Operation
- Reset values: all outputs 0; state IDLE.
- FSM states and transitions:
  - IDLE → REQ_WAIT on `start` when N≥1. Latches N, clears `epochCount`, `errCount`, address and `converged`.
  - IDLE → DONE on `start` when N=0. `converged` stays 0.
  - REQ_WAIT → FETCH when `requestFlag`=1.
  - FETCH: `memRd`=1 for one cycle at `memAddr`=current index. Then LAT.
  - LAT: counts `MEM_LAT` cycles from `memRd`. Captures `memData` into `x1`/`x2`/`t`. Then PRESENT.
  - PRESENT: `dataReady`=1 for exactly one cycle. Then RESULT.
  - RESULT waits for `ldRegFlag`. On it:
    - `errCount` += !`yEqualt`.
    - If the index is not N−1: index++, go to REQ_WAIT.
    - If the index is N−1: go to EPOCH_END. Register `endFlag` = (errors incl. this one ≠0) && (`epochCount`+1 < `MAX_EPOCH`).
  - EPOCH_END, lasting one cycle:
    - If `endFlag`: index←0, `epochCount`++, `errCount`←0, go to REQ_WAIT.
    - Otherwise: `converged` ← (errors=0), go to DONE.
  - DONE → IDLE after one cycle.
- `busy`=1 in every state except IDLE.
- `flagEOF` = (index = N−1) in PRESENT and RESULT; 0 elsewhere.
- `endFlag` is cleared on leaving EPOCH_END.
- Input handling:
  - `start` is ignored while `busy`.
  - `requestFlag` is ignored outside REQ_WAIT.
  - `ldRegFlag` is ignored outside RESULT.
- `errCount` saturates at all-ones.
- `epochCount` never exceeds `MAX_EPOCH`−1.
- `rst` mid-session: immediate return to IDLE. All outputs go to reset values, including the held sample.

## Timing
- `requestFlag` rising in REQ_WAIT → `dataReady` exactly `MEM_LAT`+2 cycles later.
- `flagEOF` is valid from the `dataReady` cycle through the `ldRegFlag` cycle.
- `endFlag` is valid the cycle after the last sample's `ldRegFlag`, which is the controller's end-flag check cycle.
- Epoch wrap: a `requestFlag` held high through EPOCH_END is serviced on entry to REQ_WAIT. No extra cycle beyond EPOCH_END.
- `ldRegFlag` in the same cycle as the transition into RESULT is not accepted. RESULT must be the current state.

## Structure
- Shared package `neuron_pkg` holds:
  - FSM state enum.
  - `memData` field offsets (X1_LSB, X2_LSB, T_BIT).
  - Default widths.
- One natural sub-module: `epoch_counter`. It holds the sample index and epoch counter, with clear, increment and wrap-at-N, and exposes `last` and `epoch_limit` outputs.

## Test plan
- N=4, MEM_LAT=1, all `yEqualt`=1. Required: one epoch, 4 `dataReady` pulses, `flagEOF` only on index 3, `endFlag`=0, `converged`=1, `epochCount`=0.
- N=3. Error on sample 1 in epoch 0, none in epoch 1. Required: `endFlag`=1 after epoch 0, `epochCount` 0→1, `errCount` cleared, session ends with `converged`=1.
- MAX_EPOCH=2, always erroring. Required: exactly 2 epochs, second `endFlag`=0, `converged`=0, `epochCount`=1.
- MEM_LAT=3. Required: `memRd` at cycle c, data captured at c+3, `dataReady` at c+4, `memAddr` sequence 0,1,2,0,…
- Protocol edges:
  - `start` with N=0 → `busy` for 1 cycle, no `memRd`.
  - `start` while busy → ignored.
  - Stray `ldRegFlag` in REQ_WAIT → `errCount` unchanged.
- `rst` pulsed during LAT. Required: all outputs 0 asynchronously. A new `start` runs a clean session from address 0.
